// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the LSU memory stage and dmem_ctrl.
// One request outstanding; rsp_valid is a single-cycle pulse.
interface dmem_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [2:0]        req_funct3;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic [1:0]        rsp_err;
  logic              init_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Word-organised data RAM controller: RV32 byte/half/word access, fixed
// response latency, post-reset clear sequencer and access fault reporting.
module dmem_ctrl #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus
);
  // state | meaning
  // CLEAR | zeroing one word per cycle after reset
  // IDLE  | ready; accepts requests, response pulse lands here
  // BUSY  | request in flight, latency down-counter running

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = XLEN / 8;
  localparam int LAT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY} state_t;

  state_t state, state_nx;

  logic [XLEN-1:0]  mem [DEPTH];
  logic [IDX_W-1:0] clr_idx, clr_nx;
  logic [LAT_W-1:0] lat_cnt, lat_nx;
  logic [XLEN-1:0]  pend_rdata, pend_rdata_nx, rsp_rdata_q, rsp_rdata_nx;
  logic [1:0]       pend_err, pend_err_nx, rsp_err_q, rsp_err_nx;
  logic             rsp_valid_q, rsp_valid_nx, done_q, done_nx;

  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [XLEN-1:0]  mem_wdata;
  logic [NB-1:0]    mem_strb;

  logic [IDX_W-1:0] req_idx;
  logic [XLEN-1:0]  rd_word, ld_data, st_data;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [NB-1:0]    st_strb;
  logic             f3_legal, oor, misal;
  logic [1:0]       req_err;

  assign req_idx = bus.req_addr[IDX_W+1:2];
  assign rd_word = mem[req_idx];

  always_comb begin
    case (bus.req_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = bus.req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !bus.req_write;
      default:                f3_legal = 1'b0;
    endcase
    oor   = {2'b00, bus.req_addr[ADDR_W-1:2]} >= DEPTH_A;
    misal = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
            ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

    if (!f3_legal)  req_err = 2'b11;
    else if (oor)   req_err = 2'b10;
    else if (misal) req_err = 2'b01;
    else            req_err = 2'b00;

    ld_data = '0;
    if (!bus.req_write && (req_err == 2'b00)) begin
      case (bus.req_funct3)
        3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
        3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
        3'b010:  ld_data = rd_word;
        3'b100:  ld_data = {24'b0, rd_byte};
        3'b101:  ld_data = {16'b0, rd_half};
        default: ld_data = '0;
      endcase
    end

    // store data is replicated across lanes so the strobe alone picks the target
    case (bus.req_funct3[1:0])
      2'b00: begin
        st_data = {NB{bus.req_wdata[7:0]}};
        st_strb = NB'(1) << bus.req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{bus.req_wdata[15:0]}};
        st_strb = bus.req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = bus.req_wdata;
        st_strb = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    clr_nx        = clr_idx;
    lat_nx        = lat_cnt;
    pend_rdata_nx = pend_rdata;
    pend_err_nx   = pend_err;
    rsp_valid_nx  = 1'b0;
    rsp_rdata_nx  = '0;
    rsp_err_nx    = 2'b00;
    done_nx       = done_q;
    mem_we        = 1'b0;
    mem_idx       = clr_idx;
    mem_wdata     = '0;
    mem_strb      = '0;
    case (state)
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_strb = '1;
        if (clr_idx == LAST_IDX) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else begin
          clr_nx = clr_idx + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_write && (req_err == 2'b00)) begin
            mem_we    = 1'b1;
            mem_idx   = req_idx;
            mem_wdata = st_data;
            mem_strb  = st_strb;
          end
          if (READ_LATENCY == 1) begin
            rsp_valid_nx = 1'b1;
            rsp_rdata_nx = ld_data;
            rsp_err_nx   = req_err;
          end else begin
            state_nx      = S_BUSY;
            lat_nx        = LAT_LOAD;
            pend_rdata_nx = ld_data;
            pend_err_nx   = req_err;
          end
        end
      end
      S_BUSY: begin
        if (lat_cnt == '0) begin
          state_nx     = S_IDLE;
          rsp_valid_nx = 1'b1;
          rsp_rdata_nx = pend_rdata;
          rsp_err_nx   = pend_err;
        end else begin
          lat_nx = lat_cnt - 1'b1;
        end
      end
      default: state_nx = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx     <= '0;
      lat_cnt     <= '0;
      pend_rdata  <= '0;
      pend_err    <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 2'b00;
      done_q      <= 1'b0;
    end else begin
      clr_idx     <= clr_nx;
      lat_cnt     <= lat_nx;
      pend_rdata  <= pend_rdata_nx;
      pend_err    <= pend_err_nx;
      rsp_valid_q <= rsp_valid_nx;
      rsp_rdata_q <= rsp_rdata_nx;
      rsp_err_q   <= rsp_err_nx;
      done_q      <= done_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_strb[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.init_done = done_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance at READ_LATENCY=1, one at 3,
// both DEPTH=16 and sharing clk/rst.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_ctrl_if #(.XLEN(32), .ADDR_W(32)) b1 ();
  dmem_ctrl_if #(.XLEN(32), .ADDR_W(32)) b3 ();

  dmem_ctrl #(.XLEN(32), .DEPTH(16), .ADDR_W(32), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave)
  );
  dmem_ctrl #(.XLEN(32), .DEPTH(16), .ADDR_W(32), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit d3, input bit v, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    if (d3) begin
      b3.req_valid = v; b3.req_write = wr; b3.req_addr = a;
      b3.req_wdata = wd; b3.req_funct3 = f3;
    end else begin
      b1.req_valid = v; b1.req_write = wr; b1.req_addr = a;
      b1.req_wdata = wd; b1.req_funct3 = f3;
    end
  endtask

  task automatic do_req(input bit d3, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rd, output logic [1:0] er,
                        output int lat);
    bit acc;
    acc = 1'b0; rd = '0; er = 2'b00; lat = 0;
    @(posedge clk); #1;
    drive(d3, 1'b1, wr, a, wd, f3);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (d3 ? b3.req_ready : b1.req_ready) begin acc = 1'b1; break; end
    end
    chk1("accept", acc, 1'b1);
    @(posedge clk); #1;
    drive(d3, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (d3 ? b3.rsp_valid : b1.rsp_valid) begin
        lat = i;
        rd  = d3 ? b3.rsp_rdata : b1.rsp_rdata;
        er  = d3 ? b3.rsp_err : b1.rsp_err;
        break;
      end
    end
  endtask

  task automatic xact(input bit d3, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, input logic [31:0] exp_rd, input logic [1:0] exp_er,
                      input string tag);
    logic [31:0] rd;
    logic [1:0]  er;
    int          lat;
    do_req(d3, wr, a, wd, f3, rd, er, lat);
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".err"}, {30'b0, er}, {30'b0, exp_er});
    chk({tag, ".latency"}, 32'(lat), d3 ? 32'd3 : 32'd1);
  endtask

  logic [31:0] st_exp [4] = '{32'h0, 32'hCAFEBABE, 32'h0, 32'hCAFE55BE};
  bit          rdy_e  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  bit          rsp_e  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  bit          seen;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

    // clear sequence with a load held on dut1 throughout
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h3C, 32'h0, 3'b010);
    @(posedge clk); @(negedge clk);
    chk1("rst.ready", b1.req_ready, 1'b0);
    chk1("rst.rsp_valid", b1.rsp_valid, 1'b0);
    chk("rst.rsp_rdata", b1.rsp_rdata, 32'h0);
    chk("rst.rsp_err", {30'b0, b1.rsp_err}, 32'h0);
    chk1("rst.init_done", b1.init_done, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); @(negedge clk);
      if (k < 16 && b1.req_ready) seen = 1'b1;
      if (k == 15) chk1("clr.done_at15", b1.init_done, 1'b0);
      if (k == 16) begin
        chk1("clr.done_at16", b1.init_done, 1'b1);
        chk1("clr.dut3_done_at16", b3.init_done, 1'b1);
        chk1("clr.ready_at16", b1.req_ready, 1'b1);
      end
    end
    chk1("clr.ready_low_during_clear", seen, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    @(negedge clk);
    chk1("clr.lw3c.valid", b1.rsp_valid, 1'b1);
    chk("clr.lw3c.rdata", b1.rsp_rdata, 32'h0);
    chk("clr.lw3c.err", {30'b0, b1.rsp_err}, 32'h0);

    // sub-word stores and loads
    xact(1'b0, 1'b1, 32'h8, 32'h11223344, 3'b010, 32'h0, 2'b00, "sw8");
    xact(1'b0, 1'b1, 32'h9, 32'h000000AB, 3'b000, 32'h0, 2'b00, "sb9");
    xact(1'b0, 1'b1, 32'hA, 32'h00008001, 3'b001, 32'h0, 2'b00, "shA");
    xact(1'b0, 1'b0, 32'h8, 32'h0, 3'b010, 32'h8001AB44, 2'b00, "lw8");
    xact(1'b0, 1'b0, 32'h9, 32'h0, 3'b000, 32'hFFFFFFAB, 2'b00, "lb9");
    xact(1'b0, 1'b0, 32'h9, 32'h0, 3'b100, 32'h000000AB, 2'b00, "lbu9");
    xact(1'b0, 1'b0, 32'hA, 32'h0, 3'b001, 32'hFFFF8001, 2'b00, "lhA");
    xact(1'b0, 1'b0, 32'hA, 32'h0, 3'b101, 32'h00008001, 2'b00, "lhuA");

    // faults and their priority
    xact(1'b0, 1'b0, 32'h6, 32'h0, 3'b010, 32'h0, 2'b01, "lw6_misal");
    xact(1'b0, 1'b1, 32'h4, 32'hA5A5A5A5, 3'b010, 32'h0, 2'b00, "sw4");
    xact(1'b0, 1'b1, 32'h5, 32'h00001234, 3'b001, 32'h0, 2'b01, "sh5_misal");
    xact(1'b0, 1'b0, 32'h4, 32'h0, 3'b010, 32'hA5A5A5A5, 2'b00, "lw4_unchanged");
    xact(1'b0, 1'b0, 32'h40, 32'h0, 3'b010, 32'h0, 2'b10, "lw40_oor");
    xact(1'b0, 1'b0, 32'h8, 32'h0, 3'b011, 32'h0, 2'b11, "ld_f3_011");
    xact(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 3'b100, 32'h0, 2'b11, "st_f3_100");
    xact(1'b0, 1'b0, 32'h8, 32'h0, 3'b010, 32'h8001AB44, 2'b00, "lw8_unchanged");
    xact(1'b0, 1'b0, 32'h41, 32'h0, 3'b011, 32'h0, 2'b11, "prio_f3_over_oor");
    xact(1'b0, 1'b0, 32'h42, 32'h0, 3'b010, 32'h0, 2'b10, "prio_oor_over_misal");

    // READ_LATENCY=1: continuous stream, store then dependent load
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFEBABE, 3'b010);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      case (i)
        0:       drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
        1:       drive(1'b0, 1'b1, 1'b1, 32'h21, 32'h00000055, 3'b000);
        2:       drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
        default: drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      endcase
      @(negedge clk);
      chk1($sformatf("stream%0d.valid", i), b1.rsp_valid, 1'b1);
      chk1($sformatf("stream%0d.ready", i), b1.req_ready, 1'b1);
      chk($sformatf("stream%0d.rdata", i), b1.rsp_rdata, st_exp[i]);
    end

    // READ_LATENCY=3: two back-to-back loads
    xact(1'b1, 1'b1, 32'h8, 32'h0BADF00D, 3'b010, 32'h0, 2'b00, "l3.sw8");
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 3'b010);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1($sformatf("l3.c%0d.ready", i), b3.req_ready, rdy_e[i]);
      chk1($sformatf("l3.c%0d.rsp_valid", i), b3.rsp_valid, rsp_e[i]);
      if (rsp_e[i]) chk($sformatf("l3.c%0d.rdata", i), b3.rsp_rdata, 32'h0BADF00D);
      if (i == 3) begin
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      end
    end

    // reset while a load is in flight on dut3
    xact(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 2'b00, "mid.sw10");
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    @(negedge clk);
    chk1("mid.ready_before_accept", b3.req_ready, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    chk1("mid.busy_ready", b3.req_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    if (b3.rsp_valid) seen = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); @(negedge clk);
      if (b3.rsp_valid) seen = 1'b1;
      if (k == 1)  chk1("mid.done_at1", b3.init_done, 1'b0);
      if (k == 15) chk1("mid.done_at15", b3.init_done, 1'b0);
      if (k == 16) chk1("mid.done_at16", b3.init_done, 1'b1);
    end
    chk1("mid.no_rsp", seen, 1'b0);
    xact(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 32'h0, 2'b00, "mid.lw10_cleared");
    xact(1'b0, 1'b0, 32'h8, 32'h0, 3'b010, 32'h0, 2'b00, "mid.dut1_lw8_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
